// File: rtl/board_b_d_gfx_arbiter.sv
// Round-robin arbiter sharing one graphics-ROM port between tile layers A and B.
// Serialises fetches, tags the address with the layer, and times out stalled reads.
module board_b_d_gfx_arbiter #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_data,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_data,
    output logic              mem_req,
    output logic [ADDR_W:0]   mem_addr,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    input  logic              err_clr,
    output logic              timeout_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam int               TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [TMR_W-1:0] timer;
    logic             last_grant;   // 0 = A, 1 = B; also names the owner of the fetch in flight
    logic             grant_b;
    logic             timed_out;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant_b = b_req;
        if (a_req && b_req) begin
            grant_b = ~last_grant;
        end
    end

    assign timed_out = (timer == TMR_LAST);

    // NOTE: sequential state uses non-blocking assignments only; the last one in a cycle wins.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            last_grant  <= 1'b1;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_data      <= '0;
            b_data      <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        last_grant <= grant_b;
                        mem_addr   <= {grant_b, (grant_b ? b_addr : a_addr)};
                        mem_req    <= 1'b1;
                        timer      <= '0;
                        busy       <= 1'b1;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    timer <= timer + 1'b1;
                    if (mem_rdy || timed_out) begin
                        // A late mem_rdy still beats the watchdog on the same edge.
                        if (last_grant) begin
                            b_data <= mem_rdy ? mem_data : '0;
                            b_ack  <= 1'b1;
                        end else begin
                            a_data <= mem_rdy ? mem_data : '0;
                            a_ack  <= 1'b1;
                        end
                        if (!mem_rdy) begin
                            timeout_err <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        state   <= ACK;
                    end
                end

                ACK: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    a_ack   <= 1'b0;
                    b_ack   <= 1'b0;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
